prn_seq_checker: RTL and testbench

//  Receive-side checker for the 10-bit XNOR PRN stream (s[n] = ~(s[n-10]^s[n-3])).

---
 rtl/prn_seq_checker_if.sv | 39 +++
 rtl/prn_seq_checker.sv | 197 +++++++++++++++++++
 tb/tb_prn_seq_checker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prn_seq_checker_if.sv
// ---------------------------------------------------------------------------
// prn_seq_checker_if
//   Bit-stream and status bundle between a PRN bit source (CDR sampler side)
//   and the prn_seq_checker.
//
//   Signals
//     bit_in     recovered data bit, meaningful when bit_valid=1
//     bit_valid  one bit per asserted cycle
//     clr_cnt    synchronous clear of err_cnt and bit_cnt
//     locked     checker is aligned to the PRN sequence
//     err_pulse  one-cycle pulse per bit error detected while locked
//     err_cnt    saturating error count, ERR_W bits
//     bit_cnt    saturating count of bits checked while locked
//
//   Modports
//     master  bit source / test logic: drives the stream, reads status
//     slave   checker: reads the stream, drives status
// ---------------------------------------------------------------------------
interface prn_seq_checker_if #(
    parameter int ERR_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic [31:0]      bit_cnt;

    modport master (
        output bit_in, bit_valid, clr_cnt,
        input  locked, err_pulse, err_cnt, bit_cnt
    );

    modport slave (
        input  bit_in, bit_valid, clr_cnt,
        output locked, err_pulse, err_cnt, bit_cnt
    );
endinterface

// File: rtl/prn_seq_checker.sv
// ---------------------------------------------------------------------------
// prn_seq_checker
//   Receive-side checker for the 10-bit XNOR PRN stream
//   s[n] = ~(s[n-10] ^ s[n-3]).
//
//   The checker first self-synchronises by shifting received bits into a
//   10-bit history and verifying that LOCK_CNT consecutive bits match the
//   predicted next bit. Once locked it switches to a free-running local
//   replica (received bits no longer enter the history), so a single line
//   error costs exactly one counted error. Too many errors inside one
//   loss-of-lock window send it back to searching.
//
//   Parameters
//     LOCK_CNT  consecutive matches needed to lock (>=1)
//     WIN_LEN   loss-of-lock window length in valid locked bits (>=2)
//     LOSS_ERR  errors within one window that force loss of lock
//     ERR_W     width of the saturating error counter (must match chk)
//
//   Ports
//     clk   clock
//     rst   synchronous, active-high reset
//     chk   prn_seq_checker_if.slave: bit_in/bit_valid/clr_cnt in,
//           locked/err_pulse/err_cnt/bit_cnt out (all outputs registered)
//
//   Build option
//     PRN_CHK_BITCNT_EN  when defined, bit_cnt counts valid bits checked
//                        while locked (saturating, 32 bits); otherwise the
//                        counter is removed and bit_cnt reads 0.
// ---------------------------------------------------------------------------
module prn_seq_checker #(
    parameter int LOCK_CNT = 16,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_ERR = 8,
    parameter int ERR_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    prn_seq_checker_if.slave   chk
);

    // Counter widths sized to hold their largest meaningful value.
    localparam int MW  = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int WPW = $clog2(WIN_LEN);
    localparam int EW  = (LOSS_ERR > 1) ? $clog2(LOSS_ERR) : 1;

    localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WPW-1:0] WIN_LAST   = WPW'(WIN_LEN - 1);
    localparam logic [EW-1:0]  LOSS_LAST  = EW'(LOSS_ERR - 1);
    localparam logic [3:0]     FILL_FULL  = 4'd10;
    // All-ones is the XNOR generator's lock-up state; it predicts itself
    // forever, so matches seen from it prove nothing about alignment.
    localparam logic [9:0]     LOCKUP     = 10'h3FF;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [9:0]       hist;
    logic [3:0]       fill;
    logic [MW-1:0]    match;
    logic [WPW-1:0]   win_pos;
    logic [EW-1:0]    win_err;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    logic pred;
    logic bit_err;
    logic lock_err;
    logic lock_bit;

    // hist[0] is the newest bit, so hist[9] is s[n-10] and hist[2] is s[n-3].
    assign pred     = ~(hist[9] ^ hist[2]);
    assign bit_err  = chk.bit_in ^ pred;
    assign lock_bit = chk.bit_valid & (state == ST_LOCKED);
    assign lock_err = lock_bit & bit_err;

    // -----------------------------------------------------------------------
    // Synchronisation / tracking FSM
    // -----------------------------------------------------------------------
    // NOTE: every register here is state, so all assignments are
    // non-blocking; blocking ones would let later statements in the same
    // edge see half-updated values and break the one-cycle output latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SEARCH;
            hist      <= '0;
            fill      <= '0;
            match     <= '0;
            win_pos   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            // NOTE: default the pulse low every cycle so it can only ever be
            // one cycle wide, including on bit_valid=0 cycles.
            err_pulse <= 1'b0;

            if (chk.bit_valid) begin
                case (state)
                    ST_SEARCH: begin
                        hist <= {hist[8:0], chk.bit_in};
                        if (fill != FILL_FULL) begin
                            // History not yet full of received bits; the
                            // prediction is meaningless until it is.
                            fill <= fill + 4'd1;
                        end else if (!bit_err && (hist != LOCKUP)) begin
                            if (match == MATCH_LAST) begin
                                state   <= ST_LOCKED;
                                locked  <= 1'b1;
                                match   <= '0;
                                win_pos <= '0;
                                win_err <= '0;
                            end else begin
                                match <= match + MW'(1);
                            end
                        end else begin
                            match <= '0;
                        end
                    end

                    ST_LOCKED: begin
                        // Local replica: the received bit never enters hist.
                        hist <= {hist[8:0], pred};
                        if (bit_err) begin
                            err_pulse <= 1'b1;
                        end

                        if (bit_err && (win_err >= LOSS_LAST)) begin
                            // Too many errors in this window. Clearing fill
                            // makes the next 10 received bits reload hist.
                            state   <= ST_SEARCH;
                            locked  <= 1'b0;
                            fill    <= '0;
                            match   <= '0;
                            win_pos <= '0;
                            win_err <= '0;
                        end else if (win_pos == WIN_LAST) begin
                            // Any error on the wrapping bit belonged to the
                            // window that is now closing, so it is dropped.
                            win_pos <= '0;
                            win_err <= '0;
                        end else begin
                            win_pos <= win_pos + WPW'(1);
                            if (bit_err) begin
                                win_err <= win_err + EW'(1);
                            end
                        end
                    end

                    default: begin
                        state  <= ST_SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Saturating error counter; clr_cnt beats a coincident error and is
    // honoured whether or not a bit is valid. Survives loss of lock.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || chk.clr_cnt) begin
            err_cnt <= '0;
        end else if (lock_err && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + ERR_W'(1);
        end
    end

`ifdef PRN_CHK_BITCNT_EN
    // -----------------------------------------------------------------------
    // Checked-bit counter: BER = err_cnt / bit_cnt.
    // -----------------------------------------------------------------------
    logic [31:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (rst || chk.clr_cnt) begin
            bit_cnt <= '0;
        end else if (lock_bit && (bit_cnt != 32'hFFFF_FFFF)) begin
            bit_cnt <= bit_cnt + 32'd1;
        end
    end

    assign chk.bit_cnt = bit_cnt;
`else
    assign chk.bit_cnt = 32'h0;
`endif

    assign chk.locked    = locked;
    assign chk.err_pulse = err_pulse;
    assign chk.err_cnt   = err_cnt;

endmodule

// File: tb/tb_prn_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_prn_seq_checker
//   Directed bench for prn_seq_checker. Two instances share one stimulus
//   stream: the default configuration (ERR_W=16) and a narrow-counter one
//   (ERR_W=4) used for the saturation case. Expected values are written
//   out by hand next to each step.
// ---------------------------------------------------------------------------
module tb_prn_seq_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic drv_bit = 1'b0;
    logic drv_valid = 1'b0;
    logic drv_clr = 1'b0;

    always #5 clk = ~clk;

    prn_seq_checker_if #(.ERR_W(16)) bus ();
    prn_seq_checker_if #(.ERR_W(4))  bus4 ();

    assign bus.bit_in     = drv_bit;
    assign bus.bit_valid  = drv_valid;
    assign bus.clr_cnt    = drv_clr;
    assign bus4.bit_in    = drv_bit;
    assign bus4.bit_valid = drv_valid;
    assign bus4.clr_cnt   = drv_clr;

    prn_seq_checker #(.LOCK_CNT(16), .WIN_LEN(64), .LOSS_ERR(8), .ERR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .chk (bus.slave)
    );

    prn_seq_checker #(.LOCK_CNT(16), .WIN_LEN(64), .LOSS_ERR(8), .ERR_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .chk (bus4.slave)
    );

`ifdef PRN_CHK_BITCNT_EN
    localparam bit BITCNT = 1'b1;
`else
    localparam bit BITCNT = 1'b0;
`endif

    int passed = 0;
    int total  = 0;

    // Reference PRN generator, independent of the DUT.
    logic [9:0] gen = 10'h001;

    // Bookkeeping for bit_cnt: bits sent while the bench expects lock.
    logic        exp_lk   = 1'b0;
    logic [31:0] exp_bits = '0;

    // Observations accumulated across multi-bit stretches.
    int pulses;
    int lock_high;
    int lock_low;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic next_gen(output logic b);
        b   = ~(gen[9] ^ gen[2]);
        gen = {gen[8:0], b};
    endtask

    // Drive one cycle of stimulus; outputs are sampled 1 time unit after
    // the edge that consumed it.
    task automatic send(input logic b, input logic v, input logic c);
        drv_bit   = b;
        drv_valid = v;
        drv_clr   = c;
        if (c)                exp_bits = '0;
        else if (v && exp_lk) exp_bits++;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_clr   = 1'b0;
        pulses    += int'(bus.err_pulse);
        lock_high += int'(bus.locked);
        lock_low  += int'(!bus.locked);
    endtask

    task automatic clean(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            next_gen(b);
            send(b, 1'b1, 1'b0);
        end
    endtask

    task automatic bad(input logic c);
        logic b;
        next_gen(b);
        send(~b, 1'b1, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_lk   = 1'b0;
        exp_bits = '0;
    endtask

    task automatic clear_obs();
        pulses    = 0;
        lock_high = 0;
        lock_low  = 0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_locked",    32'(bus.locked),    32'd0);
        check("rst_err_pulse", 32'(bus.err_pulse), 32'd0);
        check("rst_err_cnt",   32'(bus.err_cnt),   32'd0);
        check("rst_bit_cnt",   bus.bit_cnt,        32'd0);
        check("rst_err_cnt4",  32'(bus4.err_cnt),  32'd0);

        // ---------------- 1: clean lock, 1000 bits ----------------
        clean(25);
        check("t1_not_locked_25", 32'(bus.locked), 32'd0);
        clean(1);
        check("t1_locked_26", 32'(bus.locked), 32'd1);
        exp_lk = 1'b1;
        clear_obs();
        clean(974);
        check("t1_err_cnt_1000", 32'(bus.err_cnt), 32'd0);
        check("t1_no_pulses",    32'(pulses),      32'd0);
        check("t1_stays_locked", 32'(lock_low),    32'd0);
        check("t1_bit_cnt",      bus.bit_cnt,      BITCNT ? 32'd974 : 32'd0);

        // ---------------- 2: single inverted bit ----------------
        clear_obs();
        clean(199);
        bad(1'b0);
        check("t2_err_pulse", 32'(bus.err_pulse), 32'd1);
        check("t2_err_cnt",   32'(bus.err_cnt),   32'd1);
        clean(1);
        check("t2_pulse_drop", 32'(bus.err_pulse), 32'd0);
        check("t2_one_pulse",  32'(pulses),        32'd1);
        check("t2_locked",     32'(lock_low),      32'd0);

        // clr_cnt on an idle cycle clears the counters
        send(1'b0, 1'b0, 1'b1);
        check("clr_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("clr_bit_cnt", bus.bit_cnt,      32'd0);

        // ---------------- 3: 8 errors in one window -> loss ----------------
        // 1175 locked bits so far; 41 more reach the start of a fresh window.
        clean(41);
        for (int e = 0; e < 7; e++) begin
            bad(1'b0);
            clean(1);
        end
        check("t3_locked_7err", 32'(bus.locked),  32'd1);
        check("t3_err_cnt_7",   32'(bus.err_cnt), 32'd7);
        bad(1'b0);
        exp_lk = 1'b0;
        check("t3_lost_8err",   32'(bus.locked),    32'd0);
        check("t3_pulse_8err",  32'(bus.err_pulse), 32'd1);
        check("t3_err_cnt_8",   32'(bus.err_cnt),   32'd8);
        check("t3_bit_cnt",     bus.bit_cnt,        BITCNT ? 32'd56 : 32'd0);
        clean(25);
        check("t3_not_relocked_25", 32'(bus.locked), 32'd0);
        clean(1);
        check("t3_relocked_26", 32'(bus.locked),  32'd1);
        check("t3_err_retained", 32'(bus.err_cnt), 32'd8);
        exp_lk = 1'b1;

        // ---------------- 4: constant streams never lock ----------------
        do_reset();
        clear_obs();
        for (int i = 0; i < 500; i++) send(1'b1, 1'b1, 1'b0);
        check("t4_ones_never_lock", 32'(lock_high),   32'd0);
        check("t4_ones_no_pulse",   32'(pulses),      32'd0);
        check("t4_ones_err_cnt",    32'(bus.err_cnt), 32'd0);
        do_reset();
        clear_obs();
        for (int i = 0; i < 500; i++) send(1'b0, 1'b1, 1'b0);
        check("t4_zeros_never_lock", 32'(lock_high),   32'd0);
        check("t4_zeros_no_pulse",   32'(pulses),      32'd0);

        // ---------------- 5: saturation and clr vs error ----------------
        do_reset();
        clean(26);
        check("t5_locked", 32'(bus.locked), 32'd1);
        exp_lk = 1'b1;
        clear_obs();
        for (int w = 0; w < 20; w++) begin
            clean(5);
            bad(1'b0);
            clean(58);
            if (w == 14) begin
                check("t5_err_cnt4_15w", 32'(bus4.err_cnt), 32'd15);
            end
        end
        check("t5_err_cnt_20",   32'(bus.err_cnt),  32'd20);
        check("t5_err_cnt4_sat", 32'(bus4.err_cnt), 32'hF);
        check("t5_pulses",       32'(pulses),       32'd20);
        check("t5_locked_all",   32'(lock_low),     32'd0);
        check("t5_bit_cnt",      bus.bit_cnt,       BITCNT ? 32'd1280 : 32'd0);
        bad(1'b1);
        check("t5_clr_wins",      32'(bus.err_cnt),    32'd0);
        check("t5_clr_wins4",     32'(bus4.err_cnt),   32'd0);
        check("t5_clr_pulse",     32'(bus.err_pulse),  32'd1);
        check("t5_clr_pulse4",    32'(bus4.err_pulse), 32'd1);
        check("t5_clr_bit_cnt",   bus.bit_cnt,         32'd0);

        // ---------------- 6: reset while locked, gappy valid ----------------
        clean(1);
        bad(1'b0);
        check("t6_pre_err_cnt", 32'(bus.err_cnt),   32'd1);
        check("t6_pre_pulse",   32'(bus.err_pulse), 32'd1);
        rst = 1'b1;
        clean(1);
        rst      = 1'b0;
        exp_lk   = 1'b0;
        exp_bits = '0;
        check("t6_rst_locked",  32'(bus.locked),    32'd0);
        check("t6_rst_pulse",   32'(bus.err_pulse), 32'd0);
        check("t6_rst_err_cnt", 32'(bus.err_cnt),   32'd0);
        check("t6_rst_bit_cnt", bus.bit_cnt,        32'd0);
        clear_obs();
        for (int i = 0; i < 26; i++) begin
            send(~(~(gen[9] ^ gen[2])), 1'b0, 1'b0);
            if (i == 25) check("t6_not_locked_25", 32'(bus.locked), 32'd0);
            clean(1);
        end
        check("t6_relocked_26", 32'(bus.locked), 32'd1);
        exp_lk = 1'b1;
        for (int i = 0; i < 20; i++) begin
            // Wrong bit on a non-valid cycle must be ignored.
            send(~(~(gen[9] ^ gen[2])), 1'b0, 1'b0);
            clean(1);
        end
        check("t6_gap_no_pulse", 32'(pulses),      32'd0);
        check("t6_gap_err_cnt",  32'(bus.err_cnt), 32'd0);
        check("t6_bit_cnt",      bus.bit_cnt,      BITCNT ? 32'd20 : 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
